// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, receiver state encoding and a
// small majority-vote helper used by the receiver's optional filtering.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial-line synchronizer with falling-edge detect on the synchronized value.
// All flops reset to the idle (high) line level so reset never fakes an edge.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rxd_i,
    output logic rxd_s_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rxd_s_o = sync_q[SYNC_STAGES-1];
    assign fall_o  = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 UART receiver with framing-error detect.
// Define UART_RX_MAJORITY_EN to decide each bit by a 3-sample majority vote.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | line idle, waiting for a falling edge
// ST_START | counting to mid start bit, rejecting glitches
// ST_DATA  | sampling DATA_BITS bits LSB-first at mid-bit
// ST_STOP  | sampling the stop bit; good -> o_valid, low -> o_frame_err
// ST_BREAK | line held low after a framing error, waiting for it to rise
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clk_rx,
    input  logic                 i_rxd,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic rxd_s;
    logic fall;
    logic bit_s;

    uart_state_e          state_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .rxd_i  (i_rxd),
        .rxd_s_o(rxd_s),
        .fall_o (fall)
    );

`ifdef UART_RX_MAJORITY_EN
    // The two ticks before each decision tick land in the same state, so a
    // free-running history of ticked samples gives the D-2 and D-1 votes.
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= 2'b11;
        end else if (i_clk_rx) begin
            hist_q <= {hist_q[0], rxd_s};
        end
    end

    assign bit_s = maj3(hist_q[1], hist_q[0], rxd_s);
`else
    assign bit_s = rxd_s;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (fall) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (i_clk_rx) begin
                        if (cnt_q == CNT_MID) begin
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                            state_q   <= bit_s ? ST_IDLE : ST_DATA;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_clk_rx) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            shift_q   <= {bit_s, shift_q[DATA_BITS-1:1]};
                            bit_idx_q <= bit_idx_q + 1'b1;
                            if (bit_idx_q == BIT_LAST) begin
                                state_q <= ST_STOP;
                            end
                        end
                    end
                end
                ST_STOP: begin
                    if (i_clk_rx) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            if (bit_s) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= ST_BREAK;
                            end
                        end
                    end
                end
                ST_BREAK: begin
                    cnt_q <= '0;
                    if (rxd_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are driven one oversample slot at a time and the
// outputs are scored against a queue of expected bytes / framing errors.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_clk_rx = 1'b0;
    logic       i_rxd = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;

    uart_rx dut (
        .clk        (clk),
        .reset      (reset),
        .i_clk_rx   (i_clk_rx),
        .i_rxd      (i_rxd),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam logic [7:0] GLITCH_EXP = 8'h08;
`endif

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         valid_ticks[$];
    logic [7:0] model_last = 8'h00;
    int         tick_cnt = 0;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One oversample slot: line settles, then one tick near the slot end.
    task automatic drive_slot(input logic v);
        @(negedge clk);
        i_rxd    = v;
        i_clk_rx = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        i_clk_rx = 1'b1;
        tick_cnt++;
        @(negedge clk);
        i_clk_rx = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_slot(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit);
        logic v;
        for (int s = 0; s < 16; s++) drive_slot(1'b0);
        for (int b = 0; b < 8; b++) begin
            for (int s = 0; s < 16; s++) begin
                v = d[b];
                if (b == glitch_bit && s == 7) v = 1'b1;
                drive_slot(v);
            end
        end
        for (int s = 0; s < 16; s++) drive_slot(stop);
    endtask

    task automatic expect_byte(input logic [7:0] d);
        exp_t e;
        e.err  = 1'b0;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.err  = 1'b1;
        e.data = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            drive_slot(1'b1);
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (reset && (o_valid || o_frame_err)) begin
            chk("pulse_excl", 32'(o_valid & o_frame_err), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'({o_valid, o_frame_err}), 32'd0);
            end else begin
                me = exp_q.pop_front();
                chk("pulse_kind", 32'(o_frame_err), 32'(me.err));
                chk("o_data", 32'(o_data), 32'(me.err ? model_last : me.data));
                if (!me.err) begin
                    model_last = me.data;
                    valid_ticks.push_back(tick_cnt);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        bit         bad;

        repeat (3) @(negedge clk);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ferr", 32'(o_frame_err), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(4);

        // Clean frame
        expect_byte(8'hA5);
        send_frame(8'hA5, 1'b1, -1);
        drain("a5_drain");
        idle(2);
        chk("a5_busy_after", 32'(o_busy), 32'd0);
        chk("a5_data_hold", 32'(o_data), 32'hA5);

        // Short low pulse is a false start
        drive_slot(1'b0);
        drive_slot(1'b0);
        chk("glitch_busy_mid", 32'(o_busy), 32'd1);
        drive_slot(1'b0);
        drive_slot(1'b0);
        for (int i = 0; i < 4; i++) drive_slot(1'b1);
        repeat (2) @(negedge clk);
        chk("glitch_busy_end", 32'(o_busy), 32'd0);
        idle(4);
        chk("glitch_data_hold", 32'(o_data), 32'hA5);

        // Framing error, held-low break, then recovery
        expect_err();
        send_frame(8'h3C, 1'b0, -1);
        for (int i = 0; i < 40; i++) drive_slot(1'b0);
        chk("break_busy", 32'(o_busy), 32'd1);
        chk("break_data_hold", 32'(o_data), 32'hA5);
        chk("break_err_count", 32'(exp_q.size()), 32'd0);
        idle(2);
        expect_byte(8'h81);
        send_frame(8'h81, 1'b1, -1);
        drain("x81_drain");

        // Back-to-back frames, no idle between
        valid_ticks.delete();
        expect_byte(8'h00);
        expect_byte(8'hFF);
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        drain("b2b_drain");
        chk("b2b_count", 32'(valid_ticks.size()), 32'd2);
        if (valid_ticks.size() == 2)
            chk("b2b_spacing", 32'(valid_ticks[1] - valid_ticks[0]), 32'd160);

        // Reset during bit 4 of 0x5A
        d = 8'h5A;
        for (int s = 0; s < 16; s++) drive_slot(1'b0);
        for (int b = 0; b < 4; b++)
            for (int s = 0; s < 16; s++) drive_slot(d[b]);
        for (int s = 0; s < 8; s++) drive_slot(d[4]);
        @(negedge clk);
        reset = 1'b0;
        i_rxd = 1'b1;
        model_last = 8'h00;
        repeat (2) @(negedge clk);
        chk("midrst_data", 32'(o_data), 32'd0);
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_ferr", 32'(o_frame_err), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(3);
        chk("postrst_busy", 32'(o_busy), 32'd0);
        expect_byte(8'h5A);
        send_frame(8'h5A, 1'b1, -1);
        drain("x5a_drain");

        // One-tick high glitch at the bit-3 decision point
        expect_byte(GLITCH_EXP);
        send_frame(8'h00, 1'b1, 3);
        drain("glitch_drain");

        // Random traffic with occasional bad stop bits
        for (int f = 0; f < 30; f++) begin
            d   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 9) == 0);
            if (bad) expect_err();
            else     expect_byte(d);
            send_frame(d, !bad, -1);
            if (bad) begin
                for (int i = 0; i < int'($urandom_range(0, 20)); i++) drive_slot(1'b0);
                idle(int'($urandom_range(1, 3)));
            end else begin
                idle(int'($urandom_range(0, 3)));
            end
        end
        drain("rand_drain");
        idle(2);
        chk("final_busy", 32'(o_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
